// File: rtl/sobel_window_mod.sv
// sobel_window_mod
//   Streaming 3x3 window generator for a raster-order grayscale stream.
//   It keeps the two previous image rows in line buffers and three column
//   taps. When a full neighbourhood is available it presents the window on
//   d0_o..d8_o and pulses done_o for one cycle. The outputs are registered,
//   so each window appears one cycle after the pixel that completes it.
//
//   Parameters: IMG_W (pixels/row, >=3), IMG_H (rows/frame, >=3), DW (bits)
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     pixel_i / valid_i    input pixel and its qualifier
//     sof_i                start of frame; forces the pixel to (0,0)
//     d0_o..d8_o           window, rows r-2..r by columns c-2..c
//     done_o               one-cycle window strobe
//     eof_o                last window of the frame (SOBEL_WIN_EOF_EN only)
//
//   Optional feature macro: SOBEL_WIN_EOF_EN enables the eof_o port.
module sobel_window_mod #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pixel_i,
  input  logic          valid_i,
  input  logic          sof_i,
  output logic [DW-1:0] d0_o,
  output logic [DW-1:0] d1_o,
  output logic [DW-1:0] d2_o,
  output logic [DW-1:0] d3_o,
  output logic [DW-1:0] d4_o,
  output logic [DW-1:0] d5_o,
  output logic [DW-1:0] d6_o,
  output logic [DW-1:0] d7_o,
  output logic [DW-1:0] d8_o,
  output logic          done_o
`ifdef SOBEL_WIN_EOF_EN
  ,
  output logic          eof_o
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic {FILL, STREAM} state_e;

  state_e        state_q, state_d, state_eff;
  logic [CW-1:0] col_q, col_d, pcol;
  logic [RW-1:0] row_q, row_d, prow;
  logic          last_col, last_row, emit;

  logic [DW-1:0] lb0_q [IMG_W];  // row r-2
  logic [DW-1:0] lb1_q [IMG_W];  // row r-1
  logic [DW-1:0] col_top, col_mid;

  // Column taps: index 0 = row r-2, 1 = row r-1, 2 = row r.
  logic [DW-1:0] tap1_q [3];     // column c-1
  logic [DW-1:0] tap2_q [3];     // column c-2

  logic [DW-1:0] win_q [9];
  logic [DW-1:0] win_d [9];
  logic          done_q, done_d;
`ifdef SOBEL_WIN_EOF_EN
  logic          eof_q, eof_d;
`endif

  always_comb begin
    // A start-of-frame pixel is handled as if the counters were already at (0,0).
    pcol      = sof_i ? '0 : col_q;
    prow      = sof_i ? '0 : row_q;
    state_eff = sof_i ? FILL : state_q;
    last_col  = (pcol == CW'(IMG_W - 1));
    last_row  = (prow == RW'(IMG_H - 1));
    col_top   = lb0_q[pcol];
    col_mid   = lb1_q[pcol];

    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    emit    = 1'b0;

    if (valid_i) begin
      col_d   = last_col ? '0 : pcol + CW'(1);
      row_d   = last_col ? (last_row ? '0 : prow + RW'(1)) : prow;
      state_d = state_eff;
      unique case (state_eff)
        FILL: begin
          if (prow == RW'(1) && last_col) state_d = STREAM;
        end
        STREAM: begin
          // Columns 0 and 1 of each row only refill the taps.
          emit = (pcol >= CW'(2));
          if (last_row && last_col) state_d = FILL;
        end
      endcase
    end

    win_d  = win_q;
    done_d = emit;
    if (emit) begin
      win_d = '{tap2_q[0], tap1_q[0], col_top,
                tap2_q[1], tap1_q[1], col_mid,
                tap2_q[2], tap1_q[2], pixel_i};
    end
`ifdef SOBEL_WIN_EOF_EN
    eof_d = emit && last_row && last_col;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      win_q   <= '{default: '0};
      tap1_q  <= '{default: '0};
      tap2_q  <= '{default: '0};
`ifdef SOBEL_WIN_EOF_EN
      eof_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
      win_q   <= win_d;
`ifdef SOBEL_WIN_EOF_EN
      eof_q   <= eof_d;
`endif
      if (valid_i) begin
        tap2_q <= tap1_q;
        tap1_q <= '{col_top, col_mid, pixel_i};
      end
    end
  end

  // Line buffers carry no reset; stale rows are never used because windows
  // only start once two fresh rows of the current frame have been written.
  always_ff @(posedge clk) begin
    if (valid_i && !rst) begin
      lb0_q[pcol] <= col_mid;
      lb1_q[pcol] <= pixel_i;
    end
  end

  assign d0_o   = win_q[0];
  assign d1_o   = win_q[1];
  assign d2_o   = win_q[2];
  assign d3_o   = win_q[3];
  assign d4_o   = win_q[4];
  assign d5_o   = win_q[5];
  assign d6_o   = win_q[6];
  assign d7_o   = win_q[7];
  assign d8_o   = win_q[8];
  assign done_o = done_q;
`ifdef SOBEL_WIN_EOF_EN
  assign eof_o  = eof_q;
`endif

endmodule

// File: tb/tb_sobel_window_mod.sv
module tb_sobel_window_mod;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] pix4, pix3;
  logic       valid4, valid3, sof4, sof3;
  logic [8:0][7:0] o4, o3;
  logic       done4, done3;
  logic       eof4_s, eof3_s;

`ifdef SOBEL_WIN_EOF_EN
  logic eof4, eof3;
  assign eof4_s = eof4;
  assign eof3_s = eof3;
`else
  assign eof4_s = 1'b0;
  assign eof3_s = 1'b0;
`endif

  sobel_window_mod #(.IMG_W(4), .IMG_H(4), .DW(8)) dut4 (
    .clk(clk), .rst(rst), .pixel_i(pix4), .valid_i(valid4), .sof_i(sof4),
    .d0_o(o4[0]), .d1_o(o4[1]), .d2_o(o4[2]), .d3_o(o4[3]), .d4_o(o4[4]),
    .d5_o(o4[5]), .d6_o(o4[6]), .d7_o(o4[7]), .d8_o(o4[8]),
    .done_o(done4)
`ifdef SOBEL_WIN_EOF_EN
    , .eof_o(eof4)
`endif
  );

  sobel_window_mod #(.IMG_W(3), .IMG_H(3), .DW(8)) dut3 (
    .clk(clk), .rst(rst), .pixel_i(pix3), .valid_i(valid3), .sof_i(sof3),
    .d0_o(o3[0]), .d1_o(o3[1]), .d2_o(o3[2]), .d3_o(o3[3]), .d4_o(o3[4]),
    .d5_o(o3[5]), .d6_o(o3[6]), .d7_o(o3[7]), .d8_o(o3[8]),
    .done_o(done3)
`ifdef SOBEL_WIN_EOF_EN
    , .eof_o(eof3)
`endif
  );

  typedef struct {
    logic [8:0][7:0] win;
    logic            eof;
    int unsigned     cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected window for pixel (r,c) of a 4-wide frame whose pixel values are base + 4*r + c.
  function automatic logic [8:0][7:0] win4(input int base, input int r, input int c);
    logic [8:0][7:0] w;
    for (int k = 0; k < 9; k++) w[k] = 8'(base + 4 * (r - 2 + k / 3) + (c - 2 + k % 3));
    return w;
  endfunction

  task automatic chk_win(input string name, input logic [8:0][7:0] aw, input logic ae,
                         input int unsigned ac, input exp_t e);
    logic eof_bad;
`ifdef SOBEL_WIN_EOF_EN
    eof_bad = (ae !== e.eof);
`else
    eof_bad = 1'b0;
`endif
    n_cmp++;
    if (aw !== e.win || ac != e.cyc || eof_bad) begin
      n_bad++;
      $display("FAIL %s: got win=%h eof=%b cycle=%0d, expected win=%h eof=%b cycle=%0d",
               name, aw, ae, ac, e.win, e.eof, e.cyc);
    end
  endtask

  task automatic chk_val(input string name, input logic [71:0] act, input logic [71:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done4 !== 1'b0) begin
      if (q4.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL win4_unexpected: done_o=%b at cycle %0d, expected 0", done4, cyc);
      end else chk_win("win4", o4, eof4_s, cyc, q4.pop_front());
    end
    if (done3 !== 1'b0) begin
      if (q3.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL win3_unexpected: done_o=%b at cycle %0d, expected 0", done3, cyc);
      end else chk_win("win3", o3, eof3_s, cyc, q3.pop_front());
    end
  end

  task automatic frame4(input int base, input int npix, input int gap, input bit sof);
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      @(posedge clk); #1;
      pix4   = 8'(base + i);
      valid4 = 1'b1;
      sof4   = sof && (i == 0);
      if (i / 4 >= 2 && i % 4 >= 2) begin
        e.win = win4(base, i / 4, i % 4);
        e.eof = (i == 15);
        e.cyc = cyc + 1;
        q4.push_back(e);
      end
      repeat (gap) begin
        @(posedge clk); #1;
        valid4 = 1'b0;
        sof4   = 1'b0;
      end
    end
  endtask

  task automatic idle4(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid4 = 1'b0;
      sof4   = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    pix4 = '0; valid4 = 1'b0; sof4 = 1'b0;
    pix3 = '0; valid3 = 1'b0; sof3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_val("reset_done4", {71'd0, done4}, '0);
    chk_val("reset_win4", o4, '0);
    chk_val("reset_done3", {71'd0, done3}, '0);
    chk_val("reset_win3", o3, '0);
    chk_val("reset_eof", {70'd0, eof4_s, eof3_s}, '0);

    // 3x3 frame of 1..9: a single window 1..9 after the last pixel.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      pix3   = 8'(i + 1);
      valid3 = 1'b1;
      if (i == 8) begin
        for (int k = 0; k < 9; k++) e.win[k] = 8'(k + 1);
        e.eof = 1'b1;
        e.cyc = cyc + 1;
        q3.push_back(e);
      end
    end
    @(posedge clk); #1 valid3 = 1'b0;

    frame4(1, 16, 0, 1'b0);           // contiguous, first frame after reset
    frame4(1, 16, 3, 1'b0);           // 3 idle cycles after every pixel
    frame4(1, 16, 0, 1'b0);           // back-to-back pair, second with sof
    frame4(17, 16, 0, 1'b1);
    idle4(2);

    // Reset mid-frame, asserted together with a valid pixel that must be dropped.
    frame4(101, 7, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; valid4 = 1'b1; pix4 = 8'hEE; sof4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; valid4 = 1'b0;
    @(negedge clk);
    chk_val("rst_mid_win4", o4, '0);
    chk_val("rst_mid_done4", {71'd0, done4}, '0);
    frame4(1, 16, 0, 1'b0);

    // Resync mid-frame: 9 pixels of an aborted frame, then a full frame with sof.
    frame4(151, 9, 0, 1'b0);
    frame4(201, 16, 0, 1'b1);
    idle4(4);

    n_cmp++;
    if (q4.size() != 0 || q3.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d windows still pending, expected 0/0", q4.size(), q3.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
